// File: rtl/picture_loader_pkg.sv
// Shared constants for picture_loader: state encoding, image geometry and
// database word layout.
package picture_loader_pkg;

  localparam int PICTURE_SIDE = 28;
  localparam int ADDR_W       = 13;

  localparam logic [2:0] LOAD  = 3'd0;
  localparam logic [2:0] DRAIN = 3'd1;
  localparam logic [2:0] FIRE  = 3'd2;
  localparam logic [2:0] ARM   = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;

  function automatic int pix_num(input int side);
    return side * side;
  endfunction

  // A byte occupies bits [SIZE_1-2 -: 8] with a zero sign bit above it.
  function automatic int pix_shift(input int size_1);
    return size_1 - 9;
  endfunction

  localparam int PIX_NUM = pix_num(PICTURE_SIDE);

endpackage

// File: rtl/picture_loader_pixel_quant.sv
// Combinational byte-to-fixed-point conversion: unsigned pixel 0..255 becomes
// a non-negative signed SIZE_1 word equal to the byte shifted left by SIZE_1-9.
module picture_loader_pixel_quant
  import picture_loader_pkg::*;
#(
  parameter int SIZE_1 = 11
) (
  input  logic [7:0]               pix_in,
  output logic signed [SIZE_1-1:0] pix_out
);

  localparam int SHIFT = pix_shift(SIZE_1);

  logic [SIZE_1-1:0] widened;

  assign widened = SIZE_1'({1'b0, pix_in});
  assign pix_out = widened << SHIFT;

endmodule

// File: rtl/picture_loader.sv
// Streams a picture into the network database, pulses GO, then captures RESULT.
// Optional watchdog on the ARM/WAIT phase is enabled by defining LOADER_TIMEOUT_EN.
module picture_loader
  import picture_loader_pkg::*;
#(
  parameter int SIZE_1         = 11,
  parameter int picture_size   = 28,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [7:0]               s_data,
  input  logic                     s_last,
  output logic                     we_database,
  output logic signed [SIZE_1-1:0] dp_database,
  output logic [ADDR_W-1:0]        address_p_database,
  output logic                     GO,
  input  logic                     STOP,
  input  logic [4:0]               RESULT,
  output logic [4:0]               res_class,
  output logic                     res_valid,
  output logic                     busy,
  output logic                     frame_err,
  output logic                     timeout_err
);

  localparam int                NPIX     = pix_num(picture_size);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX - 1);

  logic [2:0]               state_q, state_d;
  logic [ADDR_W-1:0]        idx_q, idx_d;
  logic                     we_q, we_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic signed [SIZE_1-1:0] dp_q, dp_d;
  logic                     go_q, go_d;
  logic [4:0]               res_class_q, res_class_d;
  logic                     res_valid_q, res_valid_d;
  logic                     busy_q, busy_d;
  logic                     frame_err_q, frame_err_d;

  logic signed [SIZE_1-1:0] pix_word;
  logic                     accept;

  picture_loader_pixel_quant #(
    .SIZE_1 (SIZE_1)
  ) u_pixel_quant (
    .pix_in  (s_data),
    .pix_out (pix_word)
  );

  assign s_ready = (state_q == LOAD) || (state_q == DRAIN);
  assign accept  = s_valid && s_ready;

`ifdef LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             tmo_hit;

  // Counts cycles spent in ARM/WAIT; restarts from zero whenever it leaves.
  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ARM || state_q == WAIT) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_err    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    dp_d        = dp_q;
    go_d        = 1'b0;
    res_class_d = res_class_q;
    res_valid_d = res_valid_q;
    busy_d      = busy_q;
    frame_err_d = frame_err_q;
`ifdef LOADER_TIMEOUT_EN
    timeout_err_d = timeout_err_q;
`endif

    case (state_q)
      LOAD: begin
        if (accept) begin
          if (idx_q == '0) begin
            res_valid_d = 1'b0;
            frame_err_d = 1'b0;
            busy_d      = 1'b1;
`ifdef LOADER_TIMEOUT_EN
            timeout_err_d = 1'b0;
`endif
          end
          if (s_last && idx_q != LAST_IDX) begin
            // Early end of frame: drop this byte and wait for a fresh frame.
            frame_err_d = 1'b1;
            busy_d      = 1'b0;
            idx_d       = '0;
          end else begin
            we_d   = 1'b1;
            addr_d = idx_q;
            dp_d   = pix_word;
            if (idx_q == LAST_IDX) begin
              if (s_last) begin
                state_d = FIRE;
              end else begin
                frame_err_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = DRAIN;
              end
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end

      DRAIN: begin
        if (accept && s_last) begin
          idx_d   = '0;
          state_d = LOAD;
        end
      end

      FIRE: begin
        go_d    = 1'b1;
        state_d = ARM;
      end

      // STOP may still reflect the previous run until the top level sees GO.
      ARM: begin
        if (!STOP) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (STOP) begin
          res_class_d = RESULT;
          res_valid_d = 1'b1;
          busy_d      = 1'b0;
          idx_d       = '0;
          state_d     = LOAD;
        end
      end

      default: begin
        idx_d   = '0;
        state_d = LOAD;
      end
    endcase

`ifdef LOADER_TIMEOUT_EN
    if (tmo_hit && (state_q == ARM || (state_q == WAIT && !STOP))) begin
      timeout_err_d = 1'b1;
      res_valid_d   = 1'b0;
      busy_d        = 1'b0;
      idx_d         = '0;
      state_d       = LOAD;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      dp_q        <= '0;
      go_q        <= 1'b0;
      res_class_q <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      dp_q        <= dp_d;
      go_q        <= go_d;
      res_class_q <= res_class_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign we_database        = we_q;
  assign address_p_database = addr_q;
  assign dp_database        = dp_q;
  assign GO                 = go_q;
  assign res_class          = res_class_q;
  assign res_valid          = res_valid_q;
  assign busy               = busy_q;
  assign frame_err          = frame_err_q;

endmodule

// File: tb/tb_picture_loader.sv
// Directed bench for picture_loader: frame scenarios from a vector table plus
// hand-written reset and watchdog sequences (watchdog only with LOADER_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_picture_loader;
  import picture_loader_pkg::*;

  localparam int SIZE_1 = 11;
  localparam int TMO    = 64;
`ifdef LOADER_TIMEOUT_EN
  localparam int LONG_DELAY = 40;
`else
  localparam int LONG_DELAY = 500;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     s_valid;
  logic                     s_ready;
  logic [7:0]               s_data;
  logic                     s_last;
  logic                     we_database;
  logic signed [SIZE_1-1:0] dp_database;
  logic [12:0]              address_p_database;
  logic                     GO;
  logic                     STOP;
  logic [4:0]               RESULT;
  logic [4:0]               res_class;
  logic                     res_valid;
  logic                     busy;
  logic                     frame_err;
  logic                     timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  picture_loader #(
    .SIZE_1         (SIZE_1),
    .picture_size   (28),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .s_data             (s_data),
    .s_last             (s_last),
    .we_database        (we_database),
    .dp_database        (dp_database),
    .address_p_database (address_p_database),
    .GO                 (GO),
    .STOP               (STOP),
    .RESULT             (RESULT),
    .res_class          (res_class),
    .res_valid          (res_valid),
    .busy               (busy),
    .frame_err          (frame_err),
    .timeout_err        (timeout_err)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor: every strobe must hit the next address with the shifted byte.
  int wr_cnt  = 0;
  int go_cnt  = 0;
  int pat_off = 0;
  int prev_we_last = 0;

  always @(negedge clk) begin
    if (we_database) begin
      check("wr_addr", int'(address_p_database), wr_cnt);
      check("wr_data", int'(dp_database), ((wr_cnt + pat_off) % 256) * 4);
      wr_cnt++;
    end
    if (GO) begin
      go_cnt++;
      check("go_after_last_write", prev_we_last, 1);
    end
    prev_we_last = (we_database && address_p_database == 13'(PIX_NUM - 1)) ? 1 : 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready) begin
      tick();
      n++;
      if (n > 2000) begin
        check("s_ready_timeout", 0, 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int nbytes, input bit gaps, input bit with_last);
    for (int i = 0; i < nbytes; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      send_byte(8'((i + pat_off) % 256), with_last && (i == nbytes - 1));
      if (i == 0 && nbytes > 1) begin
        check("first_byte_res_valid", int'(res_valid), 0);
        check("first_byte_frame_err", int'(frame_err), 0);
        check("first_byte_timeout_err", int'(timeout_err), 0);
        check("first_byte_busy", int'(busy), 1);
      end
    end
  endtask

  task automatic wait_go();
    int n = 0;
    while (go_cnt == 0 && n < 20) begin
      tick();
      n++;
    end
    check("go_seen", go_cnt, 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_we", int'(we_database), 0);
    check("rst_dp", int'(dp_database), 0);
    check("rst_addr", int'(address_p_database), 0);
    check("rst_go", int'(GO), 0);
    check("rst_res_class", int'(res_class), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
  endtask

  typedef struct {
    int         nbytes;
    bit         gaps;
    int         off;
    int         exp_writes;
    bit         exp_go;
    bit         exp_ferr;
    int         stale;
    int         delay;
    logic [4:0] result;
  } vec_t;

  task automatic run_vec(input vec_t v);
    wr_cnt  = 0;
    go_cnt  = 0;
    pat_off = v.off;
    if (v.stale > 0) begin
      STOP   = 1'b1;
      RESULT = v.result ^ 5'h1f;
    end
    send_frame(v.nbytes, v.gaps, 1'b1);
    if (v.exp_go) begin
      wait_go();
      repeat (v.stale) tick();
      STOP = 1'b0;
      repeat (v.delay) tick();
      check("wait_res_valid", int'(res_valid), 0);
      check("wait_busy", int'(busy), 1);
      check("wait_s_ready", int'(s_ready), 0);
      STOP   = 1'b1;
      RESULT = v.result;
      tick();
      check("res_class", int'(res_class), int'(v.result));
      STOP = 1'b0;
      check("go_pulses", go_cnt, 1);
    end else begin
      repeat (3) tick();
      check("no_go", go_cnt, 0);
    end
    check("writes", wr_cnt, v.exp_writes);
    check("frame_err", int'(frame_err), int'(v.exp_ferr));
    check("res_valid", int'(res_valid), int'(v.exp_go));
    check("busy_done", int'(busy), 0);
    check("s_ready_done", int'(s_ready), 1);
  endtask

  vec_t vecs[5];
  vec_t post;

  initial begin
    vecs[0] = '{nbytes: 784, gaps: 0, off: 0,   exp_writes: 784, exp_go: 1, exp_ferr: 0, stale: 2, delay: LONG_DELAY, result: 5'd17};
    vecs[1] = '{nbytes: 101, gaps: 0, off: 3,   exp_writes: 100, exp_go: 0, exp_ferr: 1, stale: 0, delay: 0,  result: 5'd0};
    vecs[2] = '{nbytes: 784, gaps: 1, off: 11,  exp_writes: 784, exp_go: 1, exp_ferr: 0, stale: 0, delay: 3,  result: 5'd9};
    vecs[3] = '{nbytes: 800, gaps: 0, off: 0,   exp_writes: 784, exp_go: 0, exp_ferr: 1, stale: 0, delay: 0,  result: 5'd0};
    vecs[4] = '{nbytes: 784, gaps: 1, off: 200, exp_writes: 784, exp_go: 1, exp_ferr: 0, stale: 1, delay: 10, result: 5'd31};
    post    = '{nbytes: 784, gaps: 0, off: 0,   exp_writes: 784, exp_go: 1, exp_ferr: 0, stale: 0, delay: 4,  result: 5'd5};

    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'd0;
    s_last  = 1'b0;
    STOP    = 1'b0;
    RESULT  = 5'd0;
    repeat (2) tick();
    check_reset_outputs();
    rst = 1'b0;
    tick();

    for (int k = 0; k < 5; k++) begin
      $display("vector %0d: %0d bytes, expect %0d writes, go=%0d", k, vecs[k].nbytes, vecs[k].exp_writes, vecs[k].exp_go);
      run_vec(vecs[k]);
    end

    // Reset in the middle of a frame with ragged valid timing.
    $display("reset at idx 400");
    wr_cnt  = 0;
    go_cnt  = 0;
    pat_off = 0;
    send_frame(400, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    check_reset_outputs();
    check("pre_reset_writes", wr_cnt, 400);
    rst = 1'b0;
    tick();
    run_vec(post);

`ifdef LOADER_TIMEOUT_EN
    $display("watchdog with STOP never rising");
    wr_cnt  = 0;
    go_cnt  = 0;
    pat_off = 0;
    STOP    = 1'b0;
    send_frame(784, 1'b0, 1'b1);
    wait_go();
    repeat (62) tick();
    check("tmo_not_yet", int'(timeout_err), 0);
    tick();
    check("tmo_err", int'(timeout_err), 1);
    check("tmo_res_valid", int'(res_valid), 0);
    check("tmo_busy", int'(busy), 0);
    check("tmo_s_ready", int'(s_ready), 1);
    run_vec(post);
`else
    check("timeout_err_tied", int'(timeout_err), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog expired");
  end

endmodule
